// File: rtl/regfile_fill_engine_pkg.sv
// Shared definitions for the register-file fill engine: modes, FSM encoding,
// register file geometry and the start-request legality rule.
package regfile_fill_engine_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_WEN_W  = 4;
    localparam int COUNT_W   = 6;

    localparam logic [RF_WEN_W-1:0] WEN_ALL  = 4'hF;
    localparam logic [RF_WEN_W-1:0] WEN_NONE = 4'h0;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'd0,
        MODE_CLEAR = 2'd1,
        MODE_COPY  = 2'd2,
        MODE_RSVD  = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } fill_state_e;

    function automatic logic start_is_legal(input logic [1:0]         mode,
                                            input logic [COUNT_W-1:0] count);
        logic mode_ok;
        logic count_ok;
        mode_ok  = (fill_mode_e'(mode) != MODE_RSVD);
        count_ok = (count != 6'd0) && (count <= COUNT_W'(RF_DEPTH));
        return mode_ok && count_ok;
    endfunction

endpackage

// File: rtl/regfile_fill_engine_if.sv
// Request, register-file port and status bundle between the requester
// (touchscreen/test side) and the fill engine.
interface regfile_fill_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    import regfile_fill_engine_pkg::*;

    logic                start;
    logic [1:0]          mode;
    logic [ADDR_W-1:0]   dst_base;
    logic [ADDR_W-1:0]   src_base;
    logic [COUNT_W-1:0]  count;
    logic [DATA_W-1:0]   seed;
    logic [DATA_W-1:0]   step;
    logic                abort;
    logic [ADDR_W-1:0]   rf_raddr;
    logic [DATA_W-1:0]   rf_rdata;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [RF_WEN_W-1:0] rf_wen;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, mode, dst_base, src_base, count, seed, step, abort, rf_rdata,
        input  rf_raddr, rf_waddr, rf_wdata, rf_wen, busy, done, err
    );

    modport slave (
        input  start, mode, dst_base, src_base, count, seed, step, abort, rf_rdata,
        output rf_raddr, rf_waddr, rf_wdata, rf_wen, busy, done, err
    );

endinterface

// File: rtl/regfile_fill_engine_fill_addr_counter.sv
// Element index plus write/read address counters for a burst; addresses wrap
// naturally at the register file size, and last_o flags the final element.
module regfile_fill_engine_fill_addr_counter #(
    parameter int ADDR_W  = 5,
    parameter int COUNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load_i,
    input  logic               adv_i,
    input  logic [ADDR_W-1:0]  dst_base_i,
    input  logic [ADDR_W-1:0]  src_base_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic [ADDR_W-1:0]  wa_nxt_o,
    output logic [ADDR_W-1:0]  ra_nxt_o,
    output logic               last_o
);

    localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

    logic [COUNT_W-1:0] i_q, i_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]  wa_q, wa_d;
    logic [ADDR_W-1:0]  ra_q, ra_d;
    logic [COUNT_W-1:0] i_inc_s;

    // Load on accepted start, step after every write, otherwise hold.
    always_comb begin
        i_d   = i_q;
        cnt_d = cnt_q;
        wa_d  = wa_q;
        ra_d  = ra_q;
        if (load_i) begin
            i_d   = {COUNT_W{1'b0}};
            cnt_d = count_i;
            wa_d  = dst_base_i;
            ra_d  = src_base_i;
        end else if (adv_i) begin
            i_d  = i_q + CNT_ONE;
            wa_d = wa_q + ADDR_ONE;
            ra_d = ra_q + ADDR_ONE;
        end else begin
            i_d  = i_q;
            wa_d = wa_q;
            ra_d = ra_q;
        end
    end

    // Terminal-count compare against the element currently being written.
    always_comb begin
        i_inc_s  = i_q + CNT_ONE;
        last_o   = (i_inc_s == cnt_q);
        wa_nxt_o = wa_d;
        ra_nxt_o = ra_d;
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q   <= {COUNT_W{1'b0}};
            cnt_q <= {COUNT_W{1'b0}};
            wa_q  <= {ADDR_W{1'b0}};
            ra_q  <= {ADDR_W{1'b0}};
        end else begin
            i_q   <= i_d;
            cnt_q <= cnt_d;
            wa_q  <= wa_d;
            ra_q  <= ra_d;
        end
    end

endmodule

// File: rtl/regfile_fill_engine.sv
// Burst write sequencer ahead of the register file: FILL, CLEAR or COPY over
// an address range from a single start pulse. All outputs are registers.
module regfile_fill_engine
    import regfile_fill_engine_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input logic                  clk,
    input logic                  resetn,
    regfile_fill_engine_if.slave bus
);

    fill_state_e         state_q, state_d;
    fill_mode_e          mode_q;
    fill_mode_e          mode_nxt_s;
    logic [DATA_W-1:0]   step_q;
    logic [DATA_W-1:0]   v_q, v_d;
    logic [DATA_W-1:0]   wdata_nxt_s;
    logic                legal_s;
    logic                load_s;
    logic                adv_s;
    logic                last_s;
    logic                reject_s;
    logic [ADDR_W-1:0]   wa_nxt_s;
    logic [ADDR_W-1:0]   ra_nxt_s;

    logic [ADDR_W-1:0]   raddr_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [RF_WEN_W-1:0] wen_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    assign legal_s = start_is_legal(bus.mode, bus.count);

    regfile_fill_engine_fill_addr_counter #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_addr_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (load_s),
        .adv_i      (adv_s),
        .dst_base_i (bus.dst_base),
        .src_base_i (bus.src_base),
        .count_i    (bus.count),
        .wa_nxt_o   (wa_nxt_s),
        .ra_nxt_o   (ra_nxt_s),
        .last_o     (last_s)
    );

    // Next-state, counter control and value-register update.
    always_comb begin
        state_d  = state_q;
        load_s   = 1'b0;
        adv_s    = 1'b0;
        reject_s = 1'b0;
        v_d      = v_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && legal_s) begin
                    load_s = 1'b1;
                    v_d    = bus.seed;
                    if (fill_mode_e'(bus.mode) == MODE_COPY) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end else begin
                    reject_s = bus.start;
                end
            end
            ST_RD: begin
                v_d = bus.rf_rdata;
                if (bus.abort) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                adv_s = 1'b1;
                if (mode_q == MODE_FILL) begin
                    v_d = v_q + step_q;
                end else begin
                    v_d = v_q;
                end
                // The write presented this cycle always lands; abort only stops the next one.
                if (bus.abort || last_s) begin
                    state_d = ST_FIN;
                end else if (mode_q == MODE_COPY) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write data for the upcoming WR cycle, using the mode about to be in force.
    always_comb begin
        if (load_s) begin
            mode_nxt_s = fill_mode_e'(bus.mode);
        end else begin
            mode_nxt_s = mode_q;
        end
        if (mode_nxt_s == MODE_CLEAR) begin
            wdata_nxt_s = {DATA_W{1'b0}};
        end else begin
            wdata_nxt_s = v_d;
        end
    end

    // FSM state and latched burst context.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FILL;
            step_q  <= {DATA_W{1'b0}};
            v_q     <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            if (load_s) begin
                mode_q <= fill_mode_e'(bus.mode);
                step_q <= bus.step;
            end
        end
    end

    // Output registers are loaded from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            raddr_q <= {ADDR_W{1'b0}};
            waddr_q <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wen_q   <= WEN_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wen_q  <= (state_d == ST_WR) ? WEN_ALL : WEN_NONE;
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_FIN);
            err_q  <= reject_s;
            if (state_d == ST_WR) begin
                waddr_q <= wa_nxt_s;
                wdata_q <= wdata_nxt_s;
            end
            if (state_d == ST_RD) begin
                raddr_q <= ra_nxt_s;
            end
        end
    end

    assign bus.rf_raddr = raddr_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;
    assign bus.rf_wen   = wen_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_regfile_fill_engine.sv
// Scoreboard bench for regfile_fill_engine: stimulus queues expected bus events
// from a register-array reference model; an independent monitor compares them.
module tb_regfile_fill_engine;

    localparam int K_WR   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        int   cyc;
        logic b;
    } bz_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    logic tb_done = 1'b0;

    logic [31:0] rf  [32];
    logic [31:0] mdl [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    ev_t exp_q [$];
    bz_t bz_q  [$];
    int  n_chk  = 0;
    int  n_fail = 0;

    regfile_fill_engine_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_fill_engine #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file on the engine's write port, plus a preload port.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (bus.rf_wen == 4'hF) rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    assign bus.rf_rdata = rf[bus.rf_raddr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic take_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", 64'(kind), 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            if (kind == K_WR && e.kind == K_WR) begin
                chk("waddr", 64'(bus.rf_waddr), 64'(e.addr));
                chk("wdata", 64'(bus.rf_wdata), 64'(e.data));
            end
        end
    endtask

    // Monitor: all comparisons happen here, decoupled from stimulus.
    always begin
        @(negedge clk or negedge resetn);
        if (!resetn) begin
            #1;
            chk("rst_wen", 64'(bus.rf_wen), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_done", 64'(bus.done), 64'd0);
            chk("rst_err", 64'(bus.err), 64'd0);
            chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
            chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);
            chk("rst_raddr", 64'(bus.rf_raddr), 64'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk($sformatf("missing_event_k%0d_c%0d", exp_q[0].kind, exp_q[0].cyc), 64'd0, 64'd1);
                void'(exp_q.pop_front());
            end
            while (bz_q.size() > 0 && bz_q[0].cyc <= cyc) begin
                if (bz_q[0].cyc == cyc) chk("busy", 64'(bus.busy), 64'(bz_q[0].b));
                else chk("busy_sample_missed", 64'd0, 64'd1);
                void'(bz_q.pop_front());
            end
            if (bus.rf_wen != 4'h0) begin
                chk("wen_value", 64'(bus.rf_wen), 64'hF);
                take_event(K_WR);
            end
            if (bus.done) take_event(K_DONE);
            if (bus.err) take_event(K_ERR);
            if (tb_done || cyc > 60000) begin
                chk("watchdog", 64'(cyc > 60000), 64'd0);
                chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
                chk("busy_queue_drained", 64'(bz_q.size()), 64'd0);
                for (int k = 0; k < 32; k++) chk($sformatf("rf_final_%0d", k), 64'(rf[k]), 64'(mdl[k]));
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d; mdl[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic scramble();
        bus.mode     = 2'($urandom_range(0, 3));
        bus.dst_base = 5'($urandom_range(0, 31));
        bus.src_base = 5'($urandom_range(0, 31));
        bus.count    = 6'($urandom_range(0, 63));
        bus.seed     = $urandom;
        bus.step     = $urandom;
    endtask

    // One request: model the expected writes/done/err and busy profile, then drive.
    task automatic run_op(input logic [1:0] md, input logic [4:0] dst, input logic [4:0] src,
                          input logic [5:0] cnt, input logic [31:0] sd, input logic [31:0] stp,
                          input int ab_c, input int st_c, input logic ab0);
        int   per, nw, done_c, last, e0;
        logic legal;
        logic [4:0]  wa, ra;
        logic [31:0] d;
        legal = (md != 2'd3) && (cnt >= 6'd1) && (cnt <= 6'd32);
        per   = (md == 2'd2) ? 2 : 1;
        @(negedge clk);
        e0 = cyc + 1;
        bus.start = 1'b1; bus.mode = md; bus.dst_base = dst; bus.src_base = src;
        bus.count = cnt; bus.seed = sd; bus.step = stp; bus.abort = ab0;
        if (!legal) begin
            exp_q.push_back('{K_ERR, e0, 5'd0, 32'd0});
            done_c = 0;
            last   = 2;
        end else begin
            if (ab_c > 0 && ab_c <= per * int'(cnt)) begin
                nw = ab_c / per;
                done_c = ab_c + 1;
            end else begin
                nw = int'(cnt);
                done_c = per * int'(cnt) + 1;
            end
            for (int k = 0; k < nw; k++) begin
                wa = dst + 5'(k);
                ra = src + 5'(k);
                if (md == 2'd0) d = sd + 32'(k) * stp;
                else if (md == 2'd1) d = 32'd0;
                else d = mdl[ra];
                mdl[wa] = d;
                exp_q.push_back('{K_WR, e0 + per * (k + 1) - 1, wa, d});
            end
            exp_q.push_back('{K_DONE, e0 + done_c - 1, 5'd0, 32'd0});
            last = done_c + 1;
        end
        for (int c = 1; c <= last; c++) bz_q.push_back('{e0 + c - 1, legal && (c <= done_c)});
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (legal) scramble();
            bus.abort = legal && (c == ab_c);
            bus.start = legal && (c == st_c) && (c <= done_c);
        end
    endtask

    // Stimulus: directed cases from the test plan, a mid-burst reset, then random requests.
    initial begin
        int   e0, r, ac, sc;
        logic [1:0] md;
        logic [5:0] cn;
        resetn = 1'b1;
        pl_en = 1'b0; pl_addr = 5'd0; pl_data = 32'd0;
        bus.start = 1'b0; bus.mode = 2'd0; bus.dst_base = 5'd0; bus.src_base = 5'd0;
        bus.count = 6'd0; bus.seed = 32'd0; bus.step = 32'd0; bus.abort = 1'b0;
        #3 resetn = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 5'(k); pl_data = $urandom; mdl[k] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        run_op(2'd0, 5'd4, 5'd0, 6'd3, 32'h10, 32'h4, 0, 0, 1'b0);
        run_op(2'd0, 5'd30, 5'd0, 6'd4, 32'hFFFF_FFFE, 32'h1, 0, 0, 1'b0);
        preload(5'd0, 32'hAAAA);
        preload(5'd1, 32'h5555);
        run_op(2'd2, 5'd16, 5'd0, 6'd2, 32'd0, 32'd0, 0, 0, 1'b0);
        run_op(2'd0, 5'd3, 5'd0, 6'd0, 32'd1, 32'd1, 0, 0, 1'b0);
        run_op(2'd1, 5'd3, 5'd0, 6'd33, 32'd1, 32'd1, 0, 0, 1'b0);
        run_op(2'd3, 5'd3, 5'd0, 6'd5, 32'd1, 32'd1, 0, 0, 1'b0);
        run_op(2'd1, 5'd7, 5'd0, 6'd32, 32'd0, 32'd0, 3, 2, 1'b0);
        run_op(2'd2, 5'd3, 5'd2, 6'd4, 32'd0, 32'd0, 0, 3, 1'b1);
        run_op(2'd0, 5'd17, 5'd0, 6'd32, $urandom, $urandom, 0, 0, 1'b0);

        // Reset during the second COPY write: first write lands, second must not.
        @(negedge clk);
        e0 = cyc + 1;
        bus.start = 1'b1; bus.mode = 2'd2; bus.dst_base = 5'd20; bus.src_base = 5'd8; bus.count = 6'd8;
        exp_q.push_back('{K_WR, e0 + 1, 5'd20, mdl[8]});
        exp_q.push_back('{K_WR, e0 + 3, 5'd21, mdl[9]});
        mdl[20] = mdl[8];
        for (int c = 1; c <= 6; c++) bz_q.push_back('{e0 + c - 1, c <= 4});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
        repeat (2) @(negedge clk);
        run_op(2'd0, 5'd9, 5'd0, 6'd1, 32'h1234_5678, 32'h1, 0, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            r  = $urandom_range(0, 9);
            md = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = $urandom_range(0, 19);
            cn = (r == 0) ? 6'd0 : (r == 1) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(1, 32));
            ac = ($urandom_range(0, 3) == 0 && cn >= 6'd1 && cn <= 6'd32)
                 ? $urandom_range(1, ((md == 2'd2) ? 2 : 1) * int'(cn)) : 0;
            sc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * int'(cn) + 1) : 0;
            run_op(md, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), cn,
                   $urandom, $urandom, ac, sc, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        tb_done = 1'b1;
    end

endmodule
